mc_mem_arbiter: RTL
===================

# mc_mem_arbiter

Round-robin arbiter sharing the single-port data RAM of MyComputer among NREQ bus masters: the CPU data port, the HEX/LEDR display refresh engine and the SW/KEY loader. It sits between the masters and the RAM, serialises their accesses through a three-state FSM, and returns read data with a one-cycle acknowledge.

## Interface
- NREQ, 3: number of requesters, 2..4
- AW, 8: RAM address width
- DW, 16: RAM data width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-master request, held until ack
- we  in  NREQ  per-master write enable, valid with req
- addr  in  NREQ*AW  packed addresses; master i at [i*AW +: AW]
- wdata  in  NREQ*DW  packed write data
- lock  in  NREQ  keep grant for next access (only with MC_ARB_LOCK_EN)
- ack  out  NREQ  one-hot, one-cycle completion pulse
- rdata  out  DW  read data, valid while ack is high
- gnt  out  NREQ  one-hot current owner; zero in IDLE
- mem_addr  out  AW  RAM address
- mem_we  out  1  RAM write strobe
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, one cycle after address

## Operation
- States: IDLE -> MEM -> RESP -> IDLE; no other transitions.
- IDLE: if req != 0, pick winner by rotating priority starting at ptr+1 (mod NREQ); register gnt, mem_addr, mem_we = we[w], mem_wdata; go to MEM. If req == 0, stay.
- MEM: RAM performs the access at the end of this cycle; mem_we drops to 0 on exit; go to RESP.
- RESP: ack[w] = 1, rdata = mem_rdata (writes also return the post-access read value); ptr <= w; go to IDLE.
- Master holds req/we/addr/wdata stable from assertion until ack. Master must drop req in the cycle after ack; req still high in IDLE starts a new transaction.
- Masters not granted keep waiting; no request is dropped. With all NREQ masters requesting continuously, each is served exactly once per NREQ transactions.
- Reset values: state IDLE, ptr = NREQ-1 (master 0 wins first), gnt = 0, ack = 0, rdata = 0, mem_addr = 0, mem_we = 0, mem_wdata = 0.
- Reset mid-transaction: all outputs clear immediately (asynchronous), no ack issued, a pending write is suppressed if rst_n falls before the MEM rising edge.

## Timing
- Request-to-ack: 3 cycles from req sampled in IDLE; ack in the third cycle.
- Throughput: one access per 3 cycles; back-to-back requests from different masters incur no extra idle cycles beyond IDLE.
- gnt is high for the MEM and RESP cycles of the owner.
- mem_we is high for exactly one cycle per write.

## Configuration
- MC_ARB_LOCK_EN defined: lock port exists; if lock[w] is high in RESP and req[w] is high in the following IDLE, w is granted again regardless of rotation; ptr is unchanged while locked.
- Undefined: no lock port; pure round-robin.

## Structure
- Package mc_arb_pkg: state enum (S_IDLE, S_MEM, S_RESP), default AW/DW constants, NREQ limit.
- Sub-module mc_rr_pick: combinational rotating-priority encoder (req, ptr -> one-hot winner, valid).

## Test plan
- Single read: RAM[0x10]=0x1234, master 0 reads 0x10 -> ack[0] on cycle 3, rdata=0x1234, gnt=001 during MEM/RESP.
- Write then read: master 1 writes 0xBEEF to 0x20, then reads 0x20 -> one mem_we pulse, read returns 0xBEEF.
- Contention: all three masters request continuously from reset -> ack order 0,1,2,0,1,2.
- Late drop: master 2 keeps req high one cycle after ack -> second transaction on the same address, ack[2] again three cycles later.
- Reset in MEM of a write to 0x30 (RAM[0x30]=0x0000) -> no ack, mem_we=0 immediately, RAM[0x30] remains 0x0000, state IDLE.
- MC_ARB_LOCK_EN: master 1 requests with lock=1 while master 2 requests -> master 1 served twice consecutively, then master 2.

Source files
------------

// File: rtl/mc_arb_pkg.sv
// Shared types and constants for the MyComputer data-RAM arbiter.
// Supports the MC_ARB_LOCK_EN build option of mc_mem_arbiter.
package mc_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MEM  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam int unsigned DEF_AW   = 8;
   localparam int unsigned DEF_DW   = 16;
   localparam int unsigned NREQ_MIN = 2;
   localparam int unsigned NREQ_MAX = 4;
   localparam int unsigned PTR_W    = 2;

   // One-hot (up to NREQ_MAX wide) to binary master index.
   function automatic logic [PTR_W-1:0] oh2idx(input logic [NREQ_MAX-1:0] oh);
      oh2idx = '0;
      for (int i = 0; i < int'(NREQ_MAX); i++) begin
         if (oh[i]) oh2idx = PTR_W'(i);
      end
   endfunction

endpackage

// File: rtl/mc_rr_pick.sv
// Rotating-priority encoder: first requester after ptr (mod NREQ) wins.
module mc_rr_pick
   import mc_arb_pkg::*;
#(
   parameter int unsigned NREQ = 3
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  win,
   output logic             valid
);

   localparam int unsigned IW = (NREQ > 2) ? 2 : 1;

   logic [IW-1:0] j;

   always_comb begin
      win   = '0;
      valid = 1'b0;
      j     = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         j = IW'((32'(ptr) + k) % NREQ);
         if (!valid && req[j]) begin
            win[j] = 1'b1;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mc_mem_arbiter.sv
// Round-robin arbiter serialising NREQ masters onto one single-port data RAM.
// Define MC_ARB_LOCK_EN to add the lock port (owner may keep the grant).
module mc_mem_arbiter
   import mc_arb_pkg::*;
#(
   parameter int unsigned NREQ = 3,
   parameter int unsigned AW   = DEF_AW,
   parameter int unsigned DW   = DEF_DW
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    we,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
`ifdef MC_ARB_LOCK_EN
   input  logic [NREQ-1:0]    lock,
`endif
   output logic [NREQ-1:0]    ack,
   output logic [DW-1:0]      rdata,
   output logic [NREQ-1:0]    gnt,
   output logic [AW-1:0]      mem_addr,
   output logic               mem_we,
   output logic [DW-1:0]      mem_wdata,
   input  logic [DW-1:0]      mem_rdata
);

   state_t           state, state_d;
   logic [PTR_W-1:0] ptr, ptr_d, own, own_d, win_idx;
   logic [NREQ-1:0]  pick_win, win, gnt_d, ack_d;
   logic             pick_valid, win_valid;
   logic [AW-1:0]    mem_addr_d;
   logic             mem_we_d;
   logic [DW-1:0]    mem_wdata_d;
`ifdef MC_ARB_LOCK_EN
   logic             locked, locked_d;
`endif

   mc_rr_pick #(.NREQ(NREQ)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .win   (pick_win),
      .valid (pick_valid)
   );

   // A locked previous owner that still requests overrides the rotation.
   always_comb begin
      win       = pick_win;
      win_valid = pick_valid;
`ifdef MC_ARB_LOCK_EN
      if (locked && |(req & (NREQ'(1) << own))) begin
         win       = NREQ'(1) << own;
         win_valid = 1'b1;
      end
`endif
      win_idx = oh2idx(NREQ_MAX'(win));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         ptr       <= PTR_W'(NREQ - 1);
         own       <= '0;
         gnt       <= '0;
         ack       <= '0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
`ifdef MC_ARB_LOCK_EN
         locked    <= 1'b0;
`endif
      end else begin
         state     <= state_d;
         ptr       <= ptr_d;
         own       <= own_d;
         gnt       <= gnt_d;
         ack       <= ack_d;
         mem_addr  <= mem_addr_d;
         mem_we    <= mem_we_d;
         mem_wdata <= mem_wdata_d;
`ifdef MC_ARB_LOCK_EN
         locked    <= locked_d;
`endif
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:  if (win_valid) state_d = S_MEM;
         S_MEM:   state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      gnt_d       = gnt;
      ack_d       = '0;
      mem_addr_d  = mem_addr;
      mem_we_d    = 1'b0;
      mem_wdata_d = mem_wdata;
      ptr_d       = ptr;
      own_d       = own;
`ifdef MC_ARB_LOCK_EN
      locked_d    = locked;
`endif
      case (state)
         S_IDLE: begin
            if (win_valid) begin
               gnt_d       = win;
               own_d       = win_idx;
               mem_addr_d  = addr[int'(win_idx)*AW +: AW];
               mem_we_d    = |(we & win);
               mem_wdata_d = wdata[int'(win_idx)*DW +: DW];
`ifdef MC_ARB_LOCK_EN
               locked_d    = 1'b0;
`endif
            end
         end
         S_MEM: ack_d = gnt;
         S_RESP: begin
            gnt_d = '0;
`ifdef MC_ARB_LOCK_EN
            locked_d = |(lock & gnt);
            if (!(|(lock & gnt))) ptr_d = own;
`else
            ptr_d = own;
`endif
         end
         default: gnt_d = '0;
      endcase
   end

   // RAM data lands in the RESP cycle itself, so it is passed through gated by ack.
   assign rdata = (|ack) ? mem_rdata : '0;

endmodule
